// File: rtl/br_resolve_pkg.sv
// Shared definitions for the branch resolution unit: funct3 condition codes,
// the 2-bit BHT counter type with its reset value, and the saturating update
// rule used by the BHT.
package br_resolve_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef logic [1:0] bht_ctr_t;

  // Weakly not-taken: one taken outcome is enough to flip the prediction.
  localparam bht_ctr_t BHT_WNT = 2'b01;

  function automatic bht_ctr_t bht_next(input bht_ctr_t c, input logic taken);
    if (taken) return (c == 2'b11) ? c : c + 2'b01;
    else       return (c == 2'b00) ? c : c - 2'b01;
  endfunction

endpackage

// File: rtl/bht_2bit.sv
// Bimodal branch history table of 2-bit saturating counters.
// Ports:
//   clk, rst        clock, synchronous active-high reset (all entries -> BHT_WNT)
//   rd_idx_i        lookup index from fetch
//   rd_taken_o      combinational prediction (counter MSB) for rd_idx_i
//   upd_en_i        write the updated counter at this clock edge
//   upd_idx_i       index of the counter to train
//   upd_taken_i     resolved direction; increments when 1, decrements when 0
module bht_2bit
  import br_resolve_pkg::*;
#(
  parameter int IW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] rd_idx_i,
  output logic          rd_taken_o,
  input  logic          upd_en_i,
  input  logic [IW-1:0] upd_idx_i,
  input  logic          upd_taken_i
);

  localparam int ENTRIES = 1 << IW;

  bht_ctr_t ctr_q [ENTRIES];

  // Read sees the pre-update value when it hits the entry being written.
  assign rd_taken_o = ctr_q[rd_idx_i][1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= BHT_WNT;
    end else if (upd_en_i) begin
      ctr_q[upd_idx_i] <= bht_next(ctr_q[upd_idx_i], upd_taken_i);
    end
  end

endmodule

// File: rtl/br_resolve.sv
// Execute-stage branch resolution: decides taken/not-taken from comparator
// flags, computes the target, detects mispredictions against the fetch
// prediction, issues a one-cycle registered redirect, trains the BHT and
// keeps resolved/mispredict statistics.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   ex_valid, ex_stall               EX instruction valid / EX frozen
//   ex_is_branch/jal/jalr            one-hot instruction class
//   ex_funct3                        branch condition code
//   ex_pc, ex_imm, ex_rs1            PC, sign-extended immediate, rs1 value
//   ex_pred_taken, ex_pred_target    fetch-stage prediction
//   cmp_zero, cmp_slt, cmp_sltu      comparator flags (rs1 vs rs2)
//   if_lookup_pc, if_pred_taken      fetch BHT lookup port
//   redirect_valid, redirect_pc      registered flush/refetch request
//   br_count, mispredict_count       statistics counters
module br_resolve
  import br_resolve_pkg::*;
#(
  parameter int XLEN        = XLEN_DEF,
  parameter int BHT_ENTRIES = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic            ex_stall,
  input  logic            ex_is_branch,
  input  logic            ex_is_jal,
  input  logic            ex_is_jalr,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  input  logic            cmp_zero,
  input  logic            cmp_slt,
  input  logic            cmp_sltu,
  input  logic [XLEN-1:0] if_lookup_pc,
  output logic            if_pred_taken,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     br_count,
  output logic [31:0]     mispredict_count
);

  localparam int IW = $clog2(BHT_ENTRIES);

  logic            fire;
  logic            legal_f3;
  logic            cond_taken;
  logic            actual_taken;
  logic            mispredict;
  logic            bht_upd_en;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_plus_imm;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] refetch_pc;

  logic            redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0] redirect_pc_q,    redirect_pc_d;
  logic [31:0]     br_count_q,       br_count_d;
  logic [31:0]     mp_count_q,       mp_count_d;

  // The instruction sitting in EX during a redirect pulse is wrong-path.
  assign fire = ex_valid & ~ex_stall & ~redirect_valid_q;

  always_comb begin
    legal_f3   = 1'b1;
    cond_taken = 1'b0;
    case (ex_funct3)
      F3_BEQ:  cond_taken = cmp_zero;
      F3_BNE:  cond_taken = ~cmp_zero;
      F3_BLT:  cond_taken = cmp_slt;
      F3_BGE:  cond_taken = ~cmp_slt;
      F3_BLTU: cond_taken = cmp_sltu;
      F3_BGEU: cond_taken = ~cmp_sltu;
      default: legal_f3   = 1'b0;
    endcase
  end

  assign pc_plus4    = ex_pc + XLEN'(4);
  assign pc_plus_imm = ex_pc + ex_imm;
  assign jalr_sum    = ex_rs1 + ex_imm;
  assign target      = ex_is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : pc_plus_imm;

  assign actual_taken = ex_is_branch ? cond_taken : (ex_is_jal | ex_is_jalr);
  assign mispredict   = (actual_taken != ex_pred_taken) |
                        (actual_taken & (target != ex_pred_target));
  assign refetch_pc   = actual_taken ? target : pc_plus4;

  always_comb begin
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    br_count_d       = br_count_q;
    mp_count_d       = mp_count_q;
    if (fire) begin
      br_count_d = br_count_q + 32'd1;
      if (mispredict) begin
        redirect_valid_d = 1'b1;
        redirect_pc_d    = refetch_pc;
        mp_count_d       = mp_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      br_count_q       <= '0;
      mp_count_q       <= '0;
    end else begin
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      br_count_q       <= br_count_d;
      mp_count_q       <= mp_count_d;
    end
  end

  assign redirect_valid   = redirect_valid_q;
  assign redirect_pc      = redirect_pc_q;
  assign br_count         = br_count_q;
  assign mispredict_count = mp_count_q;

  // Reserved funct3 codes resolve not-taken but leave the history alone.
  assign bht_upd_en = fire & ex_is_branch & legal_f3;

  bht_2bit #(
    .IW (IW)
  ) u_bht (
    .clk         (clk),
    .rst         (rst),
    .rd_idx_i    (if_lookup_pc[IW+1:2]),
    .rd_taken_o  (if_pred_taken),
    .upd_en_i    (bht_upd_en),
    .upd_idx_i   (ex_pc[IW+1:2]),
    .upd_taken_i (cond_taken)
  );

  // Only the index bits of the lookup PC matter to the BHT.
  logic unused_lookup_bits;
  assign unused_lookup_bits = ^{if_lookup_pc[XLEN-1:IW+2], if_lookup_pc[1:0]};

endmodule

// File: tb/tb_br_resolve.sv
module tb_br_resolve;
  import br_resolve_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            ex_valid, ex_stall;
  logic            ex_is_branch, ex_is_jal, ex_is_jalr;
  logic [2:0]      ex_funct3;
  logic [XLEN-1:0] ex_pc, ex_imm, ex_rs1;
  logic            ex_pred_taken;
  logic [XLEN-1:0] ex_pred_target;
  logic            cmp_zero, cmp_slt, cmp_sltu;
  logic [XLEN-1:0] if_lookup_pc;
  logic            if_pred_taken;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [31:0]     br_count, mispredict_count;

  int total = 0;
  int bad   = 0;

  br_resolve #(.XLEN(XLEN), .BHT_ENTRIES(64)) dut (
    .clk              (clk),
    .rst              (rst),
    .ex_valid         (ex_valid),
    .ex_stall         (ex_stall),
    .ex_is_branch     (ex_is_branch),
    .ex_is_jal        (ex_is_jal),
    .ex_is_jalr       (ex_is_jalr),
    .ex_funct3        (ex_funct3),
    .ex_pc            (ex_pc),
    .ex_imm           (ex_imm),
    .ex_rs1           (ex_rs1),
    .ex_pred_taken    (ex_pred_taken),
    .ex_pred_target   (ex_pred_target),
    .cmp_zero         (cmp_zero),
    .cmp_slt          (cmp_slt),
    .cmp_sltu         (cmp_sltu),
    .if_lookup_pc     (if_lookup_pc),
    .if_pred_taken    (if_pred_taken),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .br_count         (br_count),
    .mispredict_count (mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic idle();
    ex_valid = 0; ex_stall = 0;
    ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0;
    ex_funct3 = 3'b000; ex_pc = '0; ex_imm = '0; ex_rs1 = '0;
    ex_pred_taken = 0; ex_pred_target = '0;
    cmp_zero = 0; cmp_slt = 0; cmp_sltu = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic branch(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                        input logic z, input logic lt, input logic ltu,
                        input logic pt, input logic [31:0] ptg);
    ex_valid = 1; ex_stall = 0;
    ex_is_branch = 1; ex_is_jal = 0; ex_is_jalr = 0;
    ex_funct3 = f3; ex_pc = pc; ex_imm = imm; ex_rs1 = '0;
    cmp_zero = z; cmp_slt = lt; cmp_sltu = ltu;
    ex_pred_taken = pt; ex_pred_target = ptg;
  endtask

  task automatic jump(input logic jal, input logic [31:0] pc, input logic [31:0] imm,
                      input logic [31:0] rs1, input logic pt, input logic [31:0] ptg);
    ex_valid = 1; ex_stall = 0;
    ex_is_branch = 0; ex_is_jal = jal; ex_is_jalr = ~jal;
    ex_funct3 = 3'b000; ex_pc = pc; ex_imm = imm; ex_rs1 = rs1;
    cmp_zero = 0; cmp_slt = 0; cmp_sltu = 0;
    ex_pred_taken = pt; ex_pred_target = ptg;
  endtask

  task automatic test_reset();
    idle();
    if_lookup_pc = 32'h100;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    total++; if (redirect_valid !== 1'b0) begin bad++; $display("FAIL reset_rv got=%0b exp=0", redirect_valid); end
    total++; if (redirect_pc !== 32'h0) begin bad++; $display("FAIL reset_rpc got=%h exp=0", redirect_pc); end
    total++; if (br_count !== 32'd0) begin bad++; $display("FAIL reset_br got=%0d exp=0", br_count); end
    total++; if (mispredict_count !== 32'd0) begin bad++; $display("FAIL reset_mp got=%0d exp=0", mispredict_count); end
    total++; if (if_pred_taken !== 1'b0) begin bad++; $display("FAIL reset_bht got=%0b exp=0", if_pred_taken); end
  endtask

  task automatic test_beq_mispredict();
    do_reset();
    if_lookup_pc = 32'h100;
    branch(F3_BEQ, 32'h100, 32'h20, 1, 0, 0, 0, 32'h0);
    total++; if (if_pred_taken !== 1'b0) begin bad++; $display("FAIL beq_old_pred got=%0b exp=0", if_pred_taken); end
    tick(); idle();
    total++; if (redirect_valid !== 1'b1) begin bad++; $display("FAIL beq_rv got=%0b exp=1", redirect_valid); end
    total++; if (redirect_pc !== 32'h120) begin bad++; $display("FAIL beq_rpc got=%h exp=120", redirect_pc); end
    total++; if (mispredict_count !== 32'd1) begin bad++; $display("FAIL beq_mp got=%0d exp=1", mispredict_count); end
    total++; if (br_count !== 32'd1) begin bad++; $display("FAIL beq_br got=%0d exp=1", br_count); end
    total++; if (if_pred_taken !== 1'b1) begin bad++; $display("FAIL beq_bht got=%0b exp=1", if_pred_taken); end
    tick();
    total++; if (redirect_valid !== 1'b0) begin bad++; $display("FAIL beq_pulse got=%0b exp=0", redirect_valid); end
  endtask

  task automatic test_bltu_not_taken();
    do_reset();
    if_lookup_pc = 32'h200;
    branch(F3_BLTU, 32'h200, 32'h10, 0, 0, 0, 0, 32'h0);
    tick(); idle();
    total++; if (redirect_valid !== 1'b0) begin bad++; $display("FAIL bltu_rv got=%0b exp=0", redirect_valid); end
    total++; if (br_count !== 32'd1) begin bad++; $display("FAIL bltu_br got=%0d exp=1", br_count); end
    total++; if (mispredict_count !== 32'd0) begin bad++; $display("FAIL bltu_mp got=%0d exp=0", mispredict_count); end
    // Counter is now 00; one taken outcome only reaches 01, still not-taken.
    branch(F3_BLTU, 32'h200, 32'h10, 0, 0, 1, 1, 32'h210);
    tick(); idle();
    total++; if (redirect_valid !== 1'b0) begin bad++; $display("FAIL bltu2_rv got=%0b exp=0", redirect_valid); end
    total++; if (if_pred_taken !== 1'b0) begin bad++; $display("FAIL bltu_bht got=%0b exp=0", if_pred_taken); end
    total++; if (br_count !== 32'd2) begin bad++; $display("FAIL bltu2_br got=%0d exp=2", br_count); end
  endtask

  task automatic test_jumps();
    do_reset();
    if_lookup_pc = 32'h300;
    jump(0, 32'h300, 32'h4, 32'h1003, 1, 32'h1006);
    tick(); idle();
    total++; if (redirect_valid !== 1'b0) begin bad++; $display("FAIL jalr_ok_rv got=%0b exp=0", redirect_valid); end
    total++; if (mispredict_count !== 32'd0) begin bad++; $display("FAIL jalr_ok_mp got=%0d exp=0", mispredict_count); end
    jump(0, 32'h300, 32'h4, 32'h1003, 1, 32'h1000);
    tick(); idle();
    total++; if (redirect_valid !== 1'b1) begin bad++; $display("FAIL jalr_bad_rv got=%0b exp=1", redirect_valid); end
    total++; if (redirect_pc !== 32'h1006) begin bad++; $display("FAIL jalr_rpc got=%h exp=1006", redirect_pc); end
    total++; if (br_count !== 32'd2) begin bad++; $display("FAIL jalr_br got=%0d exp=2", br_count); end
    tick();
    jump(1, 32'hFFFF_FFF0, 32'h20, 32'h0, 0, 32'h0);
    tick(); idle();
    total++; if (redirect_pc !== 32'h10) begin bad++; $display("FAIL jal_wrap_rpc got=%h exp=10", redirect_pc); end
    total++; if (mispredict_count !== 32'd2) begin bad++; $display("FAIL jal_mp got=%0d exp=2", mispredict_count); end
    total++; if (if_pred_taken !== 1'b0) begin bad++; $display("FAIL jump_no_bht got=%0b exp=0", if_pred_taken); end
  endtask

  task automatic test_squash();
    do_reset();
    if_lookup_pc = 32'h104;
    branch(F3_BEQ, 32'h100, 32'h20, 1, 0, 0, 0, 32'h0);
    tick();
    branch(F3_BNE, 32'h104, 32'h40, 0, 0, 0, 0, 32'h0);
    total++; if (redirect_valid !== 1'b1) begin bad++; $display("FAIL sq_first_rv got=%0b exp=1", redirect_valid); end
    tick(); idle();
    total++; if (redirect_valid !== 1'b0) begin bad++; $display("FAIL sq_second_rv got=%0b exp=0", redirect_valid); end
    total++; if (br_count !== 32'd1) begin bad++; $display("FAIL sq_br got=%0d exp=1", br_count); end
    total++; if (mispredict_count !== 32'd1) begin bad++; $display("FAIL sq_mp got=%0d exp=1", mispredict_count); end
    total++; if (if_pred_taken !== 1'b0) begin bad++; $display("FAIL sq_bht got=%0b exp=0", if_pred_taken); end
  endtask

  task automatic test_bne_train();
    logic exp_old [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    if_lookup_pc = 32'h100;
    for (int i = 0; i < 4; i++) begin
      branch(F3_BNE, 32'h100, 32'h40, 0, 0, 0, 1, 32'h140);
      total++; if (if_pred_taken !== exp_old[i]) begin bad++; $display("FAIL train_old_%0d got=%0b exp=%0b", i, if_pred_taken, exp_old[i]); end
      tick();
    end
    idle();
    total++; if (if_pred_taken !== 1'b1) begin bad++; $display("FAIL train_sat got=%0b exp=1", if_pred_taken); end
    total++; if (br_count !== 32'd4) begin bad++; $display("FAIL train_br got=%0d exp=4", br_count); end
    total++; if (mispredict_count !== 32'd0) begin bad++; $display("FAIL train_mp got=%0d exp=0", mispredict_count); end
    // 11 -> 10 stays taken, 10 -> 01 flips to not-taken.
    branch(F3_BNE, 32'h100, 32'h40, 1, 0, 0, 0, 32'h0);
    tick(); idle();
    total++; if (if_pred_taken !== 1'b1) begin bad++; $display("FAIL train_dec1 got=%0b exp=1", if_pred_taken); end
    branch(F3_BNE, 32'h100, 32'h40, 1, 0, 0, 0, 32'h0);
    tick(); idle();
    total++; if (if_pred_taken !== 1'b0) begin bad++; $display("FAIL train_dec2 got=%0b exp=0", if_pred_taken); end
  endtask

  task automatic test_stall_reserved();
    do_reset();
    if_lookup_pc = 32'h100;
    branch(F3_BEQ, 32'h100, 32'h20, 1, 0, 0, 0, 32'h0);
    ex_stall = 1;
    tick(); tick();
    total++; if (redirect_valid !== 1'b0) begin bad++; $display("FAIL stall_rv got=%0b exp=0", redirect_valid); end
    total++; if (br_count !== 32'd0) begin bad++; $display("FAIL stall_br got=%0d exp=0", br_count); end
    total++; if (mispredict_count !== 32'd0) begin bad++; $display("FAIL stall_mp got=%0d exp=0", mispredict_count); end
    total++; if (if_pred_taken !== 1'b0) begin bad++; $display("FAIL stall_bht got=%0b exp=0", if_pred_taken); end
    idle();
    branch(3'b010, 32'h100, 32'h20, 1, 1, 1, 1, 32'h120);
    tick(); idle();
    total++; if (redirect_valid !== 1'b1) begin bad++; $display("FAIL rsv_rv got=%0b exp=1", redirect_valid); end
    total++; if (redirect_pc !== 32'h104) begin bad++; $display("FAIL rsv_rpc got=%h exp=104", redirect_pc); end
    total++; if (br_count !== 32'd1) begin bad++; $display("FAIL rsv_br got=%0d exp=1", br_count); end
    total++; if (if_pred_taken !== 1'b0) begin bad++; $display("FAIL rsv_bht got=%0b exp=0", if_pred_taken); end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    if_lookup_pc = 32'h100;
    branch(F3_BEQ, 32'h100, 32'h20, 1, 0, 0, 0, 32'h0);
    tick(); idle();
    total++; if (if_pred_taken !== 1'b1) begin bad++; $display("FAIL mid_pre_bht got=%0b exp=1", if_pred_taken); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (redirect_valid !== 1'b0) begin bad++; $display("FAIL mid_rv got=%0b exp=0", redirect_valid); end
    total++; if (redirect_pc !== 32'h0) begin bad++; $display("FAIL mid_rpc got=%h exp=0", redirect_pc); end
    total++; if (br_count !== 32'd0) begin bad++; $display("FAIL mid_br got=%0d exp=0", br_count); end
    total++; if (mispredict_count !== 32'd0) begin bad++; $display("FAIL mid_mp got=%0d exp=0", mispredict_count); end
    total++; if (if_pred_taken !== 1'b0) begin bad++; $display("FAIL mid_bht got=%0b exp=0", if_pred_taken); end
    // A firing mispredict in the reset cycle must leave nothing behind.
    branch(F3_BEQ, 32'h100, 32'h20, 1, 0, 0, 0, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0; idle();
    total++; if (redirect_valid !== 1'b0) begin bad++; $display("FAIL rstfire_rv got=%0b exp=0", redirect_valid); end
    total++; if (br_count !== 32'd0) begin bad++; $display("FAIL rstfire_br got=%0d exp=0", br_count); end
    total++; if (if_pred_taken !== 1'b0) begin bad++; $display("FAIL rstfire_bht got=%0b exp=0", if_pred_taken); end
  endtask

  initial begin
    rst = 1'b1;
    if_lookup_pc = '0;
    idle();
    test_reset();
    test_beq_mispredict();
    test_bltu_not_taken();
    test_jumps();
    test_squash();
    test_bne_train();
    test_stall_reserved();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/br_resolve.md
# br_resolve

Execute-stage branch resolution unit for the RV32I core. It sits directly downstream of the branch comparator and consumes the comparator's `zero`/`slt`/`sltu` flags together with the decoded branch/jump fields. From these it decides taken/not-taken, computes the target, and detects mispredictions against the fetch-stage prediction. It issues a registered redirect/flush to fetch and trains a 2-bit bimodal branch history table (BHT) that fetch reads combinationally.

## Interface
- `XLEN`, 32, datapath width
- `BHT_ENTRIES`, 64, number of BHT counters; power of two, minimum 4
- `clk`  in  1  clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `ex_valid`  in  1  EX holds a valid control-transfer instruction
- `ex_stall`  in  1  EX frozen this cycle; no resolution accepted
- `ex_is_branch` / `ex_is_jal` / `ex_is_jalr`  in  1 each  one-hot instruction class
- `ex_funct3`  in  3  branch condition code
- `ex_pc`, `ex_imm`, `ex_rs1`  in  XLEN each  instruction PC, sign-extended immediate, rs1 value
- `ex_pred_taken`  in  1  prediction made at fetch
- `ex_pred_target`  in  XLEN  target predicted at fetch
- `cmp_zero`, `cmp_slt`, `cmp_sltu`  in  1 each  comparator flags for rs1 vs rs2
- `if_lookup_pc`  in  XLEN  fetch PC for BHT lookup
- `if_pred_taken`  out  1  combinational BHT prediction for `if_lookup_pc`
- `redirect_valid`  out  1  registered; flush younger stages and refetch
- `redirect_pc`  out  XLEN  registered refetch address
- `br_count`, `mispredict_count`  out  32 each  resolved-instruction and misprediction counters

## Operation
- `fire = ex_valid & ~ex_stall & ~redirect_valid`. The instruction in EX while `redirect_valid=1` is wrong-path and is squashed: no redirect, no BHT update, no counting.
- Conditional branches decide taken from `funct3`:
  - 000 → `zero`; 001 → `~zero`
  - 100 → `slt`; 101 → `~slt`
  - 110 → `sltu`; 111 → `~sltu`
  - 010/011 → not taken, and the BHT is not updated.
- JAL and JALR are always taken.
- Targets:
  - Branch and JAL: `pc+imm`.
  - JALR: `(rs1+imm) & ~1`.
  - Fall-through: `pc+4`.
  - All sums are modulo 2^XLEN, and wrap is silent.
- Mispredict = `actual_taken != ex_pred_taken`, OR (`actual_taken` AND `target != ex_pred_target`).
- On a mispredict with `fire`: next cycle `redirect_valid=1` and `redirect_pc = actual_taken ? target : pc+4`.
- BHT:
  - Index is `pc[log2(BHT_ENTRIES)+1:2]`; each entry is a 2-bit saturating counter.
  - On `fire` with a conditional branch (legal funct3): increment if taken (saturates at 3), decrement if not taken (saturates at 0).
  - `if_pred_taken = counter[1]`.
- Counters:
  - `br_count` increments on every `fire`.
  - `mispredict_count` increments when `fire` and mispredict.
  - Both wrap at 2^32.

## Timing
- Resolution is combinational within the `fire` cycle. Redirect has 1-cycle latency: it is registered and held for exactly one cycle.
- `redirect_valid` is not held by `ex_stall`. It is a single-cycle pulse.
- BHT update is written at the clock edge of the `fire` cycle. A same-cycle lookup of the same index returns the old value.
- Reset values:
  - `redirect_valid=0`, `redirect_pc=0`.
  - Both counters 0.
  - Every BHT entry = 2'b01 (weakly not-taken), cleared in the single reset cycle.
- Reset asserted mid-operation overrides a pending redirect and any same-cycle update.
- Back-to-back mispredicts are impossible, because the instruction after a redirect is squashed.
- `ex_valid` with `ex_stall=1` changes no state.

## Structure
- Shared package holds:
  - funct3 constants `F3_BEQ…F3_BGEU`
  - BHT counter type (2-bit) and reset value `BHT_WNT=2'b01`
  - the `XLEN` default
- One sub-module, `bht_2bit`, holds the counter array, the read port, and the saturating update port. `br_resolve` holds condition decode, target adders, mispredict logic, the redirect register, and the statistics counters.

## Test plan
- BEQ at pc=0x100, imm=0x20, `cmp_zero=1`, pred not-taken → next cycle `redirect_valid=1`, `redirect_pc=0x120`; BHT[0] goes 01→10; `mispredict_count=1`.
- BLTU at pc=0x200, `cmp_sltu=0`, pred not-taken → no redirect; BHT[0] goes 01→00; `br_count` +1.
- JALR with rs1=0x1003, imm=0x4, pred taken with target 0x1006 → no redirect. Same instruction with pred target 0x1000 → `redirect_pc=0x1006`.
- Mispredict followed by a valid branch in the next cycle → second branch squashed: single redirect pulse, counters +1 only.
- Four taken BNEs at the same PC from reset → counter goes 01→10→11→11; `if_pred_taken=1` after the first update. Check that the same-cycle lookup returns the old value.
- `ex_stall=1` with a mispredicting branch → no redirect and no counter or BHT change. `rst` in the redirect cycle → all outputs 0 and BHT=01 on the next cycle.
